// File: rtl/rx_message_packer_pkg.sv
// Shared definitions for the per-source receive packers feeding the USB
// slave-FIFO arbiter.
//   NUM_SOURCES       : number of source channels (one packer per channel)
//   MAX_WORDS_DEFAULT : default per-message word limit
//   fill_state_t      : fill FSM encoding (StIdle=0, StFill=1, StDrop=2)
//   msg_desc_t        : descriptor layout {parity, len[7:0]}
package rx_message_packer_pkg;

  localparam int unsigned NUM_SOURCES       = 4;
  localparam int unsigned MAX_WORDS_DEFAULT = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDrop = 2'd2
  } fill_state_t;

  typedef struct packed {
    logic       parity;
    logic [7:0] len;
  } msg_desc_t;

  localparam int unsigned DESC_W = $bits(msg_desc_t);

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with free-slot count.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_wr_en      : push i_wr_data (refused only when full and not popping)
//   i_rd_en      : pop the head entry (ignored when empty)
//   o_rd_data    : head entry, 0 while empty
//   o_empty      : no entries stored
//   o_free       : number of free slots
module sync_fifo_sa #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign w_do_rd = i_rd_en && (r_count != '0);
  assign w_do_wr = i_wr_en && ((r_count != FULL_CNT) || w_do_rd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_empty   = (r_count == '0);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];
  assign o_free    = FULL_CNT - r_count;

endmodule

// File: rtl/rx_message_packer.sv
// Per-source upstream stage of the USB slave-FIFO arbiter. Packs a received
// byte stream into 16-bit words and keeps one descriptor per complete message.
//   CLK, RST            : clock, asynchronous active-high reset
//   RX_DATA/VALID/EOM   : byte stream from the channel receiver
//   FIFO_Q              : show-ahead head word
//   GOT_FULL_MSG        : a complete message is waiting and not yet started
//   MSG_LEN, PARITY     : head descriptor (word count, odd byte count)
//   MSG_START, RD_REQ   : arbiter starts the head message / pops one word
//   DROPPED             : one-cycle pulse when a message was discarded
module rx_message_packer
  import rx_message_packer_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 512,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned MAX_WORDS  = MAX_WORDS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        RX_EOM,
  output logic [15:0] FIFO_Q,
  output logic        GOT_FULL_MSG,
  output logic [7:0]  MSG_LEN,
  output logic        PARITY,
  input  logic        MSG_START,
  input  logic        RD_REQ,
  output logic        DROPPED
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned QAW = $clog2(DESC_DEPTH);
  localparam logic [7:0]  MAX8 = 8'(MAX_WORDS);

  fill_state_t r_state;
  logic [7:0]  r_half;
  logic        r_half_valid;
  logic [7:0]  r_word_cnt;
  logic        r_wr_en;
  logic [15:0] r_wr_data;
  logic        r_desc_push;
  msg_desc_t   r_desc_data;
  logic        r_dropped;
  logic        r_reading;
  logic [7:0]  r_rd_cnt;
  logic        r_got_full;

  logic [DAW:0] w_word_free;
  logic         w_word_empty;
  logic [15:0]  w_word_q;
  logic [QAW:0] w_desc_free;
  logic         w_desc_empty;
  msg_desc_t    w_desc_head;
  logic         w_admit;
  logic         w_take;
  logic [7:0]   w_cnt_inc;
  logic         w_start_acc;
  logic         w_rd_fire;
  logic [7:0]   w_rd_cnt_inc;
  logic         w_desc_pop;
  logic         w_reading_next;

  // Admission counts the word/descriptor still sitting in the write stage so
  // a back-to-back message sees the space its predecessor is about to take.
  assign w_admit = (32'(w_word_free) >= MAX_WORDS + 32'(r_wr_en)) &&
                   (32'(w_desc_free) > 32'(r_desc_push));
  assign w_take    = RX_VALID && ((r_state == StFill) || ((r_state == StIdle) && w_admit));
  assign w_cnt_inc = r_word_cnt + 8'd1;

  // Fill FSM. Half-byte and word count are always clear in StIdle, so the
  // first byte of an admitted message follows the StFill path.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= StIdle;
      r_half       <= '0;
      r_half_valid <= 1'b0;
      r_word_cnt   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_desc_push  <= 1'b0;
      r_desc_data  <= '0;
      r_dropped    <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_desc_push <= 1'b0;
      r_dropped   <= 1'b0;
      if (w_take) begin
        if (r_half_valid) begin
          r_wr_en      <= 1'b1;
          r_wr_data    <= {r_half, RX_DATA};
          r_half_valid <= 1'b0;
          if (RX_EOM || (w_cnt_inc == MAX8)) begin
            r_desc_push <= 1'b1;
            r_desc_data <= '{parity: 1'b0, len: w_cnt_inc};
            r_word_cnt  <= '0;
            r_state     <= StIdle;
          end else begin
            r_word_cnt  <= w_cnt_inc;
            r_state     <= StFill;
          end
        end else if (RX_EOM) begin
          r_wr_en     <= 1'b1;
          r_wr_data   <= {RX_DATA, 8'h00};
          r_desc_push <= 1'b1;
          r_desc_data <= '{parity: 1'b1, len: w_cnt_inc};
          r_word_cnt  <= '0;
          r_state     <= StIdle;
        end else begin
          r_half       <= RX_DATA;
          r_half_valid <= 1'b1;
          r_state      <= StFill;
        end
      end else if (RX_VALID && (r_state == StIdle)) begin
        if (RX_EOM) r_dropped <= 1'b1;
        else        r_state   <= StDrop;
      end else if (RX_VALID && (r_state == StDrop) && RX_EOM) begin
        r_dropped <= 1'b1;
        r_state   <= StIdle;
      end else if ((r_state != StIdle) && (r_state != StFill) && (r_state != StDrop)) begin
        r_state <= StIdle;
      end
    end
  end

  // Read side
  assign w_start_acc    = MSG_START && r_got_full;
  assign w_rd_fire      = r_reading && RD_REQ && !w_word_empty;
  assign w_rd_cnt_inc   = r_rd_cnt + 8'd1;
  assign w_desc_pop     = w_rd_fire && (w_rd_cnt_inc == w_desc_head.len);
  assign w_reading_next = w_start_acc ? 1'b1 : (w_desc_pop ? 1'b0 : r_reading);

  // GOT_FULL_MSG drops at the edge that starts or finishes a message and only
  // re-evaluates against the post-pop descriptor FIFO one edge later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_reading  <= 1'b0;
      r_rd_cnt   <= '0;
      r_got_full <= 1'b0;
    end else begin
      r_reading  <= w_reading_next;
      if (w_start_acc)    r_rd_cnt <= '0;
      else if (w_rd_fire) r_rd_cnt <= w_rd_cnt_inc;
      r_got_full <= !w_desc_empty && !w_reading_next && !w_desc_pop;
    end
  end

  sync_fifo_sa #(
    .WIDTH (16),
    .DEPTH (DATA_DEPTH)
  ) u_word_fifo (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_wr_en   (r_wr_en),
    .i_wr_data (r_wr_data),
    .i_rd_en   (w_rd_fire),
    .o_rd_data (w_word_q),
    .o_empty   (w_word_empty),
    .o_free    (w_word_free)
  );

  sync_fifo_sa #(
    .WIDTH (DESC_W),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_wr_en   (r_desc_push),
    .i_wr_data (r_desc_data),
    .i_rd_en   (w_desc_pop),
    .o_rd_data (w_desc_head),
    .o_empty   (w_desc_empty),
    .o_free    (w_desc_free)
  );

  assign FIFO_Q       = w_word_q;
  assign GOT_FULL_MSG = r_got_full;
  assign MSG_LEN      = w_desc_head.len;
  assign PARITY       = w_desc_head.parity;
  assign DROPPED      = r_dropped;

endmodule

// File: tb/tb_rx_message_packer.sv
// Self-checking bench for rx_message_packer: directed scenarios plus random
// messages checked against a message-level reference model.
module tb_rx_message_packer;

  localparam int DATA_DEPTH = 512;
  localparam int DESC_DEPTH = 4;
  localparam int MAX_WORDS  = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_EOM;
  logic [15:0] FIFO_Q;
  logic        GOT_FULL_MSG;
  logic [7:0]  MSG_LEN;
  logic        PARITY;
  logic        MSG_START;
  logic        RD_REQ;
  logic        DROPPED;

  rx_message_packer #(
    .DATA_DEPTH (DATA_DEPTH),
    .DESC_DEPTH (DESC_DEPTH),
    .MAX_WORDS  (MAX_WORDS)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_DATA      (RX_DATA),
    .RX_VALID     (RX_VALID),
    .RX_EOM       (RX_EOM),
    .FIFO_Q       (FIFO_Q),
    .GOT_FULL_MSG (GOT_FULL_MSG),
    .MSG_LEN      (MSG_LEN),
    .PARITY       (PARITY),
    .MSG_START    (MSG_START),
    .RD_REQ       (RD_REQ),
    .DROPPED      (DROPPED)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int drop_seen = 0;
  int m_drops   = 0;

  // Reference model: expected word stream and descriptor queue.
  logic [15:0] m_words[$];
  logic [7:0]  m_len[$];
  logic        m_par[$];
  logic [7:0]  g_msg[$];

  // Pre-edge value of DROPPED: counts cycles the pulse is high.
  always @(posedge CLK) if (DROPPED === 1'b1) drop_seen++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic eom);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    RX_EOM   = eom;
    @(negedge CLK);
    RX_VALID = 1'b0;
    RX_EOM   = 1'b0;
  endtask

  // Sends g_msg (EOM on its last byte). The model splits it into segments of
  // at most 2*MAX_WORDS bytes; a segment that fails admission drops the rest.
  task automatic send_msg(input int gap_max);
    int n, pos, seg;
    logic drop;
    n = g_msg.size();
    pos = 0;
    drop = 1'b0;
    while (pos < n) begin
      seg = (n - pos > 2 * MAX_WORDS) ? 2 * MAX_WORDS : n - pos;
      if ((DATA_DEPTH - m_words.size() >= MAX_WORDS) && (m_len.size() < DESC_DEPTH)) begin
        for (int i = 0; i < seg; i += 2)
          m_words.push_back({g_msg[pos+i], (i + 1 < seg) ? g_msg[pos+i+1] : 8'h00});
        m_len.push_back(8'((seg + 1) / 2));
        m_par.push_back(seg[0]);
        pos += seg;
      end else begin
        drop = 1'b1;
        pos  = n;
      end
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge CLK);
      drive_byte(g_msg[i], (i == n - 1));
    end
    chk("dropped_pulse", {15'b0, DROPPED}, {15'b0, drop});
    if (drop) m_drops++;
  endtask

  task automatic wait_gfm();
    int w;
    w = 0;
    while (GOT_FULL_MSG !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("gfm_wait", {15'b0, GOT_FULL_MSG}, 16'd1);
  endtask

  task automatic drain_one();
    int n;
    wait_gfm();
    chk("msg_len", {8'b0, MSG_LEN}, {8'b0, m_len[0]});
    chk("parity", {15'b0, PARITY}, {15'b0, m_par[0]});
    MSG_START = 1'b1;
    tick();
    MSG_START = 1'b0;
    chk("gfm_after_start", {15'b0, GOT_FULL_MSG}, 16'd0);
    n = m_len.pop_front();
    void'(m_par.pop_front());
    for (int i = 0; i < n; i++) begin
      chk("fifo_q", FIFO_Q, m_words.pop_front());
      RD_REQ = 1'b1;
      tick();
      RD_REQ = 1'b0;
    end
    chk("gfm_after_last", {15'b0, GOT_FULL_MSG}, 16'd0);
  endtask

  task automatic drain_all();
    while (m_len.size() > 0) drain_one();
  endtask

  task automatic rand_msg(input int n);
    g_msg.delete();
    for (int i = 0; i < n; i++) g_msg.push_back(8'($urandom));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_q"},    FIFO_Q, 16'd0);
    chk({tag, "_gfm"},  {15'b0, GOT_FULL_MSG}, 16'd0);
    chk({tag, "_len"},  {8'b0, MSG_LEN}, 16'd0);
    chk({tag, "_par"},  {15'b0, PARITY}, 16'd0);
    chk({tag, "_drop"}, {15'b0, DROPPED}, 16'd0);
  endtask

  initial begin
    logic [7:0] bb[3];
    int drops_before;
    RST = 1'b1; RX_DATA = '0; RX_VALID = 1'b0; RX_EOM = 1'b0;
    MSG_START = 1'b0; RD_REQ = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    RST = 1'b0;
    tick();

    // Four bytes, even message
    g_msg = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_msg(0);
    chk("t1_gfm_n0", {15'b0, GOT_FULL_MSG}, 16'd0);
    tick();
    chk("t1_gfm_n1", {15'b0, GOT_FULL_MSG}, 16'd0);
    tick();
    chk("t1_gfm_n2", {15'b0, GOT_FULL_MSG}, 16'd1);
    chk("t1_len", {8'b0, MSG_LEN}, 16'd2);
    chk("t1_par", {15'b0, PARITY}, 16'd0);
    chk("t1_q", FIFO_Q, 16'hA1B2);
    drain_one();
    tick();
    chk("t1_gfm_idle", {15'b0, GOT_FULL_MSG}, 16'd0);

    // Odd message
    g_msg = '{8'h11, 8'h22, 8'h33};
    send_msg(0);
    tick(); tick();
    chk("t2_len", {8'b0, MSG_LEN}, 16'd2);
    chk("t2_par", {15'b0, PARITY}, 16'd1);
    chk("t2_q", FIFO_Q, 16'h1122);
    drain_one();

    // 520 bytes: cutoff at MAX_WORDS then a 5-word remainder
    rand_msg(520);
    send_msg(0);
    tick(); tick();
    chk("t3_len1", {8'b0, MSG_LEN}, 16'd255);
    chk("t3_par1", {15'b0, PARITY}, 16'd0);
    drain_one();
    tick();
    chk("t3_len2", {8'b0, MSG_LEN}, 16'd5);
    drain_one();

    // Descriptor FIFO full: fifth message dropped
    drops_before = drop_seen;
    for (int k = 0; k < 5; k++) begin
      rand_msg(2);
      send_msg(0);
    end
    tick();
    chk("t4_drop_cnt", 16'(drop_seen - drops_before), 16'd1);
    drain_one();
    rand_msg(2);
    send_msg(0);
    drain_all();

    // Stream a message while the previous one is drained
    rand_msg(8);
    send_msg(0);
    wait_gfm();
    MSG_START = 1'b1;
    tick();
    MSG_START = 1'b0;
    void'(m_len.pop_front());
    void'(m_par.pop_front());
    for (int i = 0; i < 3; i++) bb[i] = 8'($urandom);
    for (int c = 0; c < 4; c++) begin
      chk("conc_q", FIFO_Q, m_words.pop_front());
      if (c < 3) begin
        RX_DATA = bb[c]; RX_VALID = 1'b1; RX_EOM = (c == 2);
      end
      RD_REQ = 1'b1;
      tick();
      RD_REQ = 1'b0; RX_VALID = 1'b0; RX_EOM = 1'b0;
      chk("conc_gfm_low", {15'b0, GOT_FULL_MSG}, 16'd0);
    end
    tick();
    chk("conc_gfm_b", {15'b0, GOT_FULL_MSG}, 16'd1);
    m_words.push_back({bb[0], bb[1]});
    m_words.push_back({bb[2], 8'h00});
    m_len.push_back(8'd2);
    m_par.push_back(1'b1);
    drain_one();

    // Reset mid-fill
    drive_byte(8'h5A, 1'b0);
    drive_byte(8'h6B, 1'b0);
    drive_byte(8'h7C, 1'b0);
    RST = 1'b1;
    #1;
    chk_outputs_zero("rst_fill");
    tick();
    RST = 1'b0;
    tick();

    // Reset mid-read
    rand_msg(6);
    send_msg(0);
    wait_gfm();
    MSG_START = 1'b1;
    tick();
    MSG_START = 1'b0;
    RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0;
    RST = 1'b1;
    #1;
    chk_outputs_zero("rst_read");
    m_words.delete(); m_len.delete(); m_par.delete();
    tick();
    RST = 1'b0;
    MSG_START = 1'b1; RD_REQ = 1'b1;
    tick(); tick();
    MSG_START = 1'b0; RD_REQ = 1'b0;
    tick();
    chk("stray_gfm", {15'b0, GOT_FULL_MSG}, 16'd0);
    chk("stray_q", FIFO_Q, 16'd0);
    rand_msg(5);
    send_msg(0);
    drain_one();

    // Random messages, lengths and drain patterns
    for (int it = 0; it < 40; it++) begin
      rand_msg(($urandom_range(0, 7) == 0) ? $urandom_range(200, 600) : $urandom_range(1, 12));
      send_msg(2);
      if ($urandom_range(0, 2) == 0) drain_all();
      else if (($urandom_range(0, 1) == 0) && (m_len.size() > 0)) drain_one();
    end
    drain_all();
    tick();
    chk("drop_total", 16'(drop_seen), 16'(m_drops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
